search_req_arbiter: RTL

Shares one binary search engine between NUM_REQ independent requesters. Each requester presents a key with a valid/ready handshake. Requests are granted round-robin and issued one at a time as a single-cycle key/valid pulse to the engine. The engine's found or no-match result is routed back to the granted requester. The block sits between client logic and the search engine, and stalls issue while software is rewriting the search table.

---
 rtl/search_req_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/search_req_arbiter.sv
// search_req_arbiter: round-robin sharing of one binary search engine among NUM_REQ requesters.
// Define SEARCH_ARB_TIMEOUT_EN to add a watchdog that releases a WAIT that the engine never answers.
module search_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IW            = $clog2(DEPTH),
  localparam int PW            = $clog2(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_key,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          cfg_busy,
  output logic [DATA_WIDTH-1:0]         eng_key,
  output logic                          eng_key_valid,
  input  logic                          eng_resp_valid,
  input  logic [IW-1:0]                 eng_index,
  input  logic                          eng_no_match,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_found,
  output logic [IW-1:0]                 rsp_index,
  output logic                          rsp_timeout,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, grant, win_idx, win_next;
  logic [DATA_WIDTH-1:0] win_key;
  logic                  win_found, issue, eng_hit, eng_miss, to_fire, done;
  int                    scan_idx;

  // Scan downward in offset so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_key   = '0;
    scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan_idx);
        win_key   = req_key[scan_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign win_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign issue    = (state == IDLE) && !cfg_busy && win_found;
  assign eng_hit  = (state == WAIT) && eng_resp_valid;
  assign eng_miss = (state == WAIT) && !eng_resp_valid && eng_no_match;
  assign done     = eng_hit || eng_miss || to_fire;

`ifdef SEARCH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  assign to_fire = (state == WAIT) && !eng_resp_valid && !eng_no_match &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Rst)                 to_cnt <= '0;
    else if (issue)          to_cnt <= '0;
    else if (state == WAIT)  to_cnt <= to_cnt + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) rsp_timeout <= 1'b0;
    else     rsp_timeout <= to_fire;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign to_fire     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = WAIT;
      WAIT:    if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (issue) req_ready[win_idx] = 1'b1;
  end

  // Issue stage toward the engine and response stage back to the granted requester.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rr_ptr        <= '0;
      eng_key       <= '0;
      eng_key_valid <= 1'b0;
      rsp_valid     <= '0;
      rsp_found     <= 1'b0;
      rsp_index     <= '0;
    end else begin
      eng_key_valid <= issue;
      rsp_valid     <= '0;
      rsp_found     <= 1'b0;
      rsp_index     <= '0;
      if (issue) begin
        eng_key <= win_key;
        rr_ptr  <= win_next;
      end
      if (eng_hit) begin
        rsp_valid[grant] <= 1'b1;
        rsp_found        <= 1'b1;
        rsp_index        <= eng_index;
      end else if (eng_miss || to_fire) begin
        rsp_valid[grant] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (issue) grant <= win_idx;
  end

endmodule
